// File: rtl/imem_stream_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
// Contents: loader FSM state enum, frame constants, datapath widths and
// the packed payload of one instruction-memory write.
package imem_load_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned HDR_BYTES = 3;

  localparam logic [BYTE_W-1:0] MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  // One instruction-memory write: byte address plus assembled word
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } imem_wr_t;

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master: loader side (consumes bytes, drives the write port and status).
// slave : host/memory side (drives bytes, observes the write port and status).
interface imem_stream_loader_if;
  import imem_load_pkg::*;

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              we;
  logic [WORD_W-1:0] Instrucoes;
  logic [ADDR_W-1:0] ADDR_INST;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, we, Instrucoes, ADDR_INST, cpu_hold, load_done, load_err
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, we, Instrucoes, ADDR_INST, cpu_hold, load_done, load_err
  );

endinterface

// File: rtl/imem_stream_loader_byte_packer.sv
// Packs accepted bytes into little-endian 32-bit words.
// Ports: clk, rst (async high), clear (restart at lane 0), in_valid/in_data
// (accepted byte), word_valid_c (high with the 4th byte of a word),
// word_c (assembled word, valid while word_valid_c is high).
module byte_packer
  import imem_load_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  logic [1:0]        lane;
  logic [WORD_W-1:0] shreg;

  // New bytes enter at the top so the first byte ends up in bits [7:0]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane  <= 2'd0;
      shreg <= '0;
    end else if (clear) begin
      lane  <= 2'd0;
      shreg <= '0;
    end else if (in_valid) begin
      lane  <= 2'(lane + 2'd1);
      shreg <= {in_data, shreg[WORD_W-1:BYTE_W]};
    end
  end

  // Word is completed combinationally so the write can register on the same edge
  assign word_valid_c = in_valid && (lane == 2'd3);
  assign word_c       = {in_data, shreg[WORD_W-1:BYTE_W]};

endmodule

// File: rtl/imem_stream_loader.sv
// Framed byte-stream loader for the instruction memory.
// Frame: MAGIC, CNT_LO, CNT_HI, then 4*N little-endian data bytes; each word is
// written once at BASE_ADDR + 4*index while the CPU is held.
// Ports: clk, rst (async high), bus (master modport: byte stream in, write
// strobe/data/address, cpu_hold, load_done, load_err out).
module imem_stream_loader
  import imem_load_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       MAX_WORDS = 1024,
  parameter logic [BYTE_W-1:0] MAGIC     = MAGIC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_stream_loader_if.master bus
);

  localparam logic [63:0] LAST_ADDR = 64'(BASE_ADDR) + 64'(MAX_WORDS - 1) * 64'd4;

  // Parameter sanity checks at elaboration
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_align
    $error("BASE_ADDR must be 4-byte aligned");
  end
  if ((MAX_WORDS == 0) || (MAX_WORDS > 65535)) begin : g_bad_max
    $error("MAX_WORDS must be in 1..65535");
  end
  if (LAST_ADDR > 64'h0000_0000_FFFF_FFFF) begin : g_bad_wrap
    $error("BASE_ADDR + 4*(MAX_WORDS-1) overflows 32 bits");
  end

  state_t             state_q, state_d;
  logic [BYTE_W-1:0]  cnt_lo_q, cnt_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  imem_wr_t           wr_q, wr_d;
  logic               we_q, we_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;

  logic               accept_c;
  logic               is_magic_c;
  logic [CNT_W-1:0]   hdr_cnt_c;
  logic               pk_clear_c;
  logic               pk_valid_c;
  logic               pk_word_valid_c;
  logic [WORD_W-1:0]  pk_word_c;

  assign accept_c   = bus.byte_valid && ready_q;
  assign is_magic_c = (bus.byte_data == MAGIC);
  assign hdr_cnt_c  = {bus.byte_data, cnt_lo_q};

  byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (pk_clear_c),
    .in_valid     (pk_valid_c),
    .in_data      (bus.byte_data),
    .word_valid_c (pk_word_valid_c),
    .word_c       (pk_word_c)
  );

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_SYNC;
      cnt_lo_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      wr_q     <= '{addr: BASE_ADDR, data: '0};
      we_q     <= 1'b0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_lo_q <= cnt_lo_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      we_q     <= we_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    we_d       = 1'b0;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    pk_clear_c = 1'b0;
    pk_valid_c = 1'b0;

    case (state_q)
      S_SYNC: begin
        if (accept_c && is_magic_c) begin
          state_d    = S_LEN0;
          pk_clear_c = 1'b1;
        end
      end
      S_LEN0: begin
        if (accept_c) begin
          cnt_lo_d = bus.byte_data;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept_c) begin
          cnt_d      = hdr_cnt_c;
          idx_d      = '0;
          pk_clear_c = 1'b1;
          if (hdr_cnt_c == '0) begin
            state_d = S_DONE;
          end else if (32'(hdr_cnt_c) > 32'(MAX_WORDS)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        pk_valid_c = accept_c;
        if (pk_word_valid_c) begin
          we_d      = 1'b1;
          wr_d.data = pk_word_c;
          wr_d.addr = ADDR_W'(BASE_ADDR + (32'(idx_q) << 2));
          idx_d     = CNT_W'(idx_q + 16'd1);
          if (CNT_W'(idx_q + 16'd1) == cnt_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Done/hold update one cycle after entry; MAGIC re-arms the hold
        if (accept_c && is_magic_c) begin
          state_d = S_LEN0;
          done_d  = 1'b0;
          hold_d  = 1'b1;
        end else begin
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end
      end
      S_ERR: begin
        err_d  = 1'b1;
        hold_d = 1'b1;
      end
      default: begin
        state_d = S_SYNC;
      end
    endcase
  end

  // Ready is registered from the next state so it drops on entry to S_ERR
  assign ready_d = (state_d != S_ERR);

  assign bus.byte_ready = ready_q;
  assign bus.we         = we_q;
  assign bus.Instrucoes = wr_q.data;
  assign bus.ADDR_INST  = wr_q.addr;
  assign bus.cpu_hold   = hold_q;
  assign bus.load_done  = done_q;
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: randomized frames and gaps
// compared against a frame-level reference model of the expected writes.
module tb_imem_stream_loader;
  import imem_load_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 1024;
  localparam logic [7:0]  MG   = 8'hA5;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;

  imem_stream_loader_if bus();

  imem_stream_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW),
    .MAGIC     (MG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int done_rise_cyc = -1;
  int last_acc_cyc = -1;
  logic prev_done = 1'b0;
  wr_t obs_q[$];
  wr_t exp_q[$];

  // Record every write strobe and the rising edge of load_done
  always @(negedge clk) begin
    wr_t w;
    cyc = cyc + 1;
    if (bus.we === 1'b1) begin
      w.addr = bus.ADDR_INST;
      w.data = bus.Instrucoes;
      obs_q.push_back(w);
      last_we_cyc = cyc;
    end
    if (bus.load_done === 1'b1 && prev_done !== 1'b1) done_rise_cyc = cyc;
    prev_done = bus.load_done;
  end

  // Reference: writes implied by a frame (leading non-MAGIC bytes skipped)
  task automatic model_frame(input logic [7:0] s[$]);
    int p = 0;
    int n;
    wr_t w;
    exp_q.delete();
    while (p < s.size() && s[p] != MG) p++;
    p++;
    n = int'({s[p+1], s[p]});
    if (n > int'(MAXW)) return;
    for (int i = 0; i < n; i++) begin
      w.addr = BASE + 32'(4 * i);
      w.data = {s[p+2+4*i+3], s[p+2+4*i+2], s[p+2+4*i+1], s[p+2+4*i]};
      exp_q.push_back(w);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
    end
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.byte_ready !== 1'b1) begin
      checks++;
      $display("FAIL send_byte: byte_ready=%b required 1 within 50 cycles", bus.byte_ready);
    end
    @(posedge clk);
    last_acc_cyc = cyc + 1;
    #1 bus.byte_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int maxgap);
    foreach (s[i]) send_byte(s[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    done_rise_cyc = -1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.we !== 1'b0) $display("FAIL reset_we: got %b required 0", bus.we); else passed++;
    checks++; if (bus.Instrucoes !== 32'h0) $display("FAIL reset_instr: got %h required 0", bus.Instrucoes); else passed++;
    checks++; if (bus.ADDR_INST !== BASE) $display("FAIL reset_addr: got %h required %h", bus.ADDR_INST, BASE); else passed++;
    checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL reset_hold: got %b required 1", bus.cpu_hold); else passed++;
    checks++; if (bus.load_done !== 1'b0) $display("FAIL reset_done: got %b required 0", bus.load_done); else passed++;
    checks++; if (bus.load_err !== 1'b0) $display("FAIL reset_err: got %b required 0", bus.load_err); else passed++;
    checks++; if (bus.byte_ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", bus.byte_ready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.byte_ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", bus.byte_ready); else passed++;
  endtask

  task automatic test_basic();
    logic [7:0] s[$];
    apply_reset();
    s = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    model_frame(s);
    send_stream(s, 0);
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() != 2) $display("FAIL basic_count: got %0d required 2", obs_q.size()); else passed++;
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0].addr !== 32'h0 || obs_q[0].data !== 32'h0000_0013) $display("FAIL basic_w0: got %h@%h required 00000013@00000000", obs_q[0].data, obs_q[0].addr); else passed++;
      checks++; if (obs_q[1].addr !== 32'h4 || obs_q[1].data !== 32'h0010_0093) $display("FAIL basic_w1: got %h@%h required 00100093@00000004", obs_q[1].data, obs_q[1].addr); else passed++;
    end
    checks++; if (done_rise_cyc != last_we_cyc + 1) $display("FAIL basic_done_timing: got cycle %0d required %0d", done_rise_cyc, last_we_cyc + 1); else passed++;
    checks++; if (bus.cpu_hold !== 1'b0) $display("FAIL basic_hold: got %b required 0", bus.cpu_hold); else passed++;
  endtask

  task automatic test_garbage();
    logic [7:0] s[$];
    apply_reset();
    s = '{8'hFF, 8'h00, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_frame(s);
    send_stream(s, 3);
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL garbage_count: got %0d required %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data)
        $display("FAIL garbage_w%0d: got %h@%h required %h@%h", i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
      else passed++;
    end
    checks++; if (bus.load_done !== 1'b1) $display("FAIL garbage_done: got %b required 1", bus.load_done); else passed++;
  endtask

  task automatic test_zero();
    logic [7:0] s[$];
    apply_reset();
    s = '{8'hA5, 8'h00, 8'h00};
    send_stream(s, 0);
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() != 0) $display("FAIL zero_no_we: got %0d writes required 0", obs_q.size()); else passed++;
    checks++; if (done_rise_cyc != last_acc_cyc + 1) $display("FAIL zero_done_timing: got cycle %0d required %0d", done_rise_cyc, last_acc_cyc + 1); else passed++;
    checks++; if (bus.cpu_hold !== 1'b0) $display("FAIL zero_hold: got %b required 0", bus.cpu_hold); else passed++;
  endtask

  task automatic test_error();
    logic [7:0] s[$];
    apply_reset();
    s = '{8'hA5, 8'h01, 8'h04};
    send_stream(s, 1);
    repeat (3) @(negedge clk);
    checks++; if (bus.load_err !== 1'b1) $display("FAIL err_flag: got %b required 1", bus.load_err); else passed++;
    checks++; if (bus.byte_ready !== 1'b0) $display("FAIL err_ready: got %b required 0", bus.byte_ready); else passed++;
    checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL err_hold: got %b required 1", bus.cpu_hold); else passed++;
    checks++; if (obs_q.size() != 0) $display("FAIL err_no_we: got %0d writes required 0", obs_q.size()); else passed++;
    apply_reset();
    s = '{8'hA5, 8'h02, 8'h00};
    repeat (8) s.push_back(8'($urandom));
    model_frame(s);
    send_stream(s, 2);
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL err_recover_count: got %0d required %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data)
        $display("FAIL err_recover_w%0d: got %h@%h required %h@%h", i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
      else passed++;
    end
    checks++; if (bus.load_err !== 1'b0) $display("FAIL err_cleared: got %b required 0", bus.load_err); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] s[$];
    apply_reset();
    s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stream(s, 0);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.we !== 1'b0) $display("FAIL mid_we: got %b required 0", bus.we); else passed++;
    checks++; if (bus.Instrucoes !== 32'h0) $display("FAIL mid_instr: got %h required 0", bus.Instrucoes); else passed++;
    checks++; if (bus.ADDR_INST !== BASE) $display("FAIL mid_addr: got %h required %h", bus.ADDR_INST, BASE); else passed++;
    checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL mid_hold: got %b required 1", bus.cpu_hold); else passed++;
    checks++; if (bus.byte_ready !== 1'b0) $display("FAIL mid_ready: got %b required 0", bus.byte_ready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    s = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_stream(s, 1);
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() != 1) $display("FAIL mid_reload_count: got %0d required 1", obs_q.size()); else passed++;
    if (obs_q.size() == 1) begin
      checks++; if (obs_q[0].addr !== BASE || obs_q[0].data !== 32'h1234_5678) $display("FAIL mid_reload_w0: got %h@%h required 12345678@%h", obs_q[0].data, obs_q[0].addr, BASE); else passed++;
    end
  endtask

  task automatic test_reload();
    logic [7:0] s[$];
    obs_q.delete();
    done_rise_cyc = -1;
    send_byte(MG, 0);
    @(negedge clk);
    checks++; if (bus.load_done !== 1'b0) $display("FAIL reload_done_drop: got %b required 0", bus.load_done); else passed++;
    checks++; if (bus.cpu_hold !== 1'b1) $display("FAIL reload_hold_rise: got %b required 1", bus.cpu_hold); else passed++;
    s = '{MG, 8'h01, 8'h00};
    repeat (4) s.push_back(8'($urandom));
    model_frame(s);
    s.delete(0);
    send_stream(s, 2);
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() != 1) $display("FAIL reload_count: got %0d required 1", obs_q.size()); else passed++;
    if (obs_q.size() == 1) begin
      checks++; if (obs_q[0].addr !== exp_q[0].addr || obs_q[0].data !== exp_q[0].data) $display("FAIL reload_w0: got %h@%h required %h@%h", obs_q[0].data, obs_q[0].addr, exp_q[0].data, exp_q[0].addr); else passed++;
    end
    checks++; if (done_rise_cyc != last_we_cyc + 1) $display("FAIL reload_done_timing: got cycle %0d required %0d", done_rise_cyc, last_we_cyc + 1); else passed++;
  endtask

  // Back-to-back frames with random sizes, data, leading junk and gaps
  task automatic test_random();
    logic [7:0] s[$];
    int n;
    logic [7:0] b;
    for (int f = 0; f < 5; f++) begin
      s.delete();
      obs_q.delete();
      done_rise_cyc = -1;
      n = int'($urandom_range(1, 6));
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 254));
        if (b == MG) b = 8'h5A;
        s.push_back(b);
      end
      s.push_back(MG);
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      repeat (4 * n) s.push_back(8'($urandom));
      model_frame(s);
      send_stream(s, (f % 2 == 0) ? 0 : 3);
      repeat (3) @(negedge clk);
      checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d required %0d", f, obs_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data)
          $display("FAIL rand%0d_w%0d: got %h@%h required %h@%h", f, i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
        else passed++;
      end
      checks++; if (done_rise_cyc != last_we_cyc + 1) $display("FAIL rand%0d_done_timing: got cycle %0d required %0d", f, done_rise_cyc, last_we_cyc + 1); else passed++;
    end
  endtask

  // Largest legal image: exactly MAX_WORDS words
  task automatic test_max();
    logic [7:0] s[$];
    apply_reset();
    s = '{MG, 8'(MAXW), 8'(MAXW >> 8)};
    repeat (4 * MAXW) s.push_back(8'($urandom));
    model_frame(s);
    send_stream(s, 0);
    repeat (3) @(negedge clk);
    checks++; if (obs_q.size() != exp_q.size()) $display("FAIL max_count: got %0d required %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data)
        $display("FAIL max_w%0d: got %h@%h required %h@%h", i, obs_q[i].data, obs_q[i].addr, exp_q[i].data, exp_q[i].addr);
      else passed++;
    end
    checks++; if (bus.load_err !== 1'b0) $display("FAIL max_err: got %b required 0", bus.load_err); else passed++;
    checks++; if (bus.load_done !== 1'b1) $display("FAIL max_done: got %b required 1", bus.load_done); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_basic();
    test_garbage();
    test_zero();
    test_error();
    test_reset_mid();
    test_reload();
    test_random();
    test_max();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Writer end of the instruction-memory load port (we / Instrucoes / ADDR_INST) of the RV pipeline.
- Accepts a framed byte stream from a host-side source (UART RX, JTAG shim or UVM byte driver) and packs bytes into 32-bit little-endian words.
- Issues one single-cycle write per word at consecutive word addresses.
- Holds the CPU via cpu_hold until the program image has been fully written.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be 4-aligned.
- MAX_WORDS, 1024, largest accepted word count; a larger header count is an error.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- byte_valid  in  1  source presents byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts; transfer occurs when byte_valid && byte_ready at a rising edge.
- we  out  1  one-cycle instruction-memory write strobe.
- Instrucoes  out  32  write data, little-endian assembled word.
- ADDR_INST  out  32  write byte address.
- cpu_hold  out  1  keeps the pipeline stalled or in reset while 1.
- load_done  out  1  image fully written; stays 1 until the next frame starts.
- load_err  out  1  sticky header error.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Frame format: MAGIC, CNT_LO, CNT_HI, then 4*N data bytes. N = {CNT_HI, CNT_LO}. Each word is sent b0 first; b0 maps to Instrucoes[7:0].
- Reset values:
  - we = 0, Instrucoes = 0, ADDR_INST = BASE_ADDR.
  - cpu_hold = 1, load_done = 0, load_err = 0.
  - byte_ready = 0 while rst = 1. It is registered and goes to 1 on the first edge after rst deasserts.
  - State = S_SYNC.
- States and transitions:
  - S_SYNC: non-MAGIC bytes are accepted and discarded. MAGIC -> S_LEN0.
  - S_LEN0: latch CNT_LO -> S_LEN1.
  - S_LEN1: latch CNT_HI.
    - N = 0 -> S_DONE.
    - N > MAX_WORDS -> S_ERR.
    - Otherwise -> S_DATA, with word index = 0 and byte lane = 0.
  - S_DATA: each accepted byte fills the current lane; the lane counter wraps 3 -> 0.
    - On the 4th byte: at that same edge, we <= 1, Instrucoes <= assembled word, ADDR_INST <= BASE_ADDR + 4*index. index increments.
    - When index reaches N -> S_DONE.
  - S_DONE: load_done = 1 and cpu_hold = 0. Both are registered and assert exactly one cycle after the last we pulse.
    - Further bytes are accepted.
    - MAGIC restarts a load: load_done <= 0, cpu_hold <= 1, state -> S_LEN0.
    - Any other byte is discarded.
  - S_ERR: load_err = 1, byte_ready = 0, cpu_hold stays 1. Only rst exits this state.
- byte_ready = 1 in every state except S_ERR. There is no internal backpressure: a 4-byte word can never overrun a 1-cycle write. Back-to-back bytes every cycle are supported.
- we is high for exactly 1 cycle per word. Instrucoes and ADDR_INST stay stable until the next word's write edge.
- Gaps: byte_valid gaps of any length are legal; the state and partial word are preserved.
- Wrap: the address is computed as an unsigned 32-bit sum; BASE_ADDR + 4*(MAX_WORDS-1) must not overflow. This is a parameter constraint checked by an elaboration assertion.
- Reset mid-frame: the partial word and count are discarded and the FSM returns to S_SYNC. Words already written remain in memory. cpu_hold returns to 1.
- N = 0 edge case: load_done and cpu_hold change one cycle after CNT_HI is accepted, and no we pulse occurs.

Decomposition:
- Package imem_load_pkg:
  - state enum (S_SYNC, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR);
  - MAGIC default;
  - HDR_BYTES = 3;
  - count width = 16.
- Sub-module byte_packer: 2-bit lane counter plus 32-bit shift register. Outputs are word_valid (a pulse on the 4th byte) and word. It has a clear input driven by the FSM when a frame starts.

Test Plan:
- Header A5 02 00, data 13 00 00 00 93 00 10 00, bytes every cycle -> we pulses twice. First write: ADDR_INST = 0x0, Instrucoes = 0x00000013. Second write: ADDR_INST = 0x4, Instrucoes = 0x00100093. load_done = 1 and cpu_hold = 0 one cycle after the 2nd pulse.
- Leading garbage FF 00 then A5 01 00 EF BE AD DE with random valid gaps -> exactly one write: 0xDEADBEEF at 0x0. The garbage bytes are dropped.
- A5 00 00 -> no we; load_done = 1 on the cycle after CNT_HI.
- A5 01 04 (N = 1025 > MAX_WORDS) -> load_err = 1, byte_ready = 0, cpu_hold = 1, no we. After rst, a valid frame loads normally.
- rst asserted after 6 of 8 data bytes of a 2-word frame -> all outputs return to reset values immediately (asynchronously). A following frame writes from BASE_ADDR again.
- After a completed load, a second frame A5 01 00 + word -> load_done drops and cpu_hold rises on MAGIC acceptance. The new word is written at BASE_ADDR, then done re-asserts.
